// File: rtl/dispn_scan_if.sv
// -----------------------------------------------------------------------------
// dispn_scan_if
// Bundles the application-side and pin-side signals of the multiplexed
// 7-segment display driver.
//
//   data        hex nibbles, digit i = data[4i+3:4i]
//   dp_in       decimal point request per digit (1 = lit)
//   en_in       digit enable per digit (1 = shown)
//   load        one-cycle strobe capturing data/dp_in/en_in into the shadow
//   lzb         leading-zero blanking enable (live)
//   bright      PWM on-time code (live)
//   an          anodes, active low
//   seg         segments gfedcba, active low
//   dp          decimal point, active low
//   pending     shadow holds an uncommitted load
//   frame_done  one-cycle pulse on each commit
//
// master: application / testbench side.  slave: the display driver.
// -----------------------------------------------------------------------------
interface dispn_scan_if #(
    parameter int N_DIGITS = 4,
    parameter int AN_W     = 8,
    parameter int BRIGHT_W = 4
);
    logic [4*N_DIGITS-1:0] data;
    logic [N_DIGITS-1:0]   dp_in;
    logic [N_DIGITS-1:0]   en_in;
    logic                  load;
    logic                  lzb;
    logic [BRIGHT_W-1:0]   bright;
    logic [AN_W-1:0]       an;
    logic [6:0]            seg;
    logic                  dp;
    logic                  pending;
    logic                  frame_done;

    modport master (
        output data, dp_in, en_in, load, lzb, bright,
        input  an, seg, dp, pending, frame_done
    );

    modport slave (
        input  data, dp_in, en_in, load, lzb, bright,
        output an, seg, dp, pending, frame_done
    );
endinterface

// File: rtl/dispn_scan.sv
// -----------------------------------------------------------------------------
// dispn_scan
// N-digit multiplexed 7-segment display driver with per-digit enable and
// decimal point, leading-zero blanking, PWM brightness and an anti-ghosting
// blank guard at the start of every digit dwell. Display contents are double
// buffered: a load fills the shadow, and the shadow is committed to the active
// set only on the last cycle of the last digit, so a frame never tears.
//
// Ports:
//   clk   system clock
//   rst   asynchronous, active-high reset
//   bus   dispn_scan_if.slave (see interface file for signal list)
//
// Parameter constraints: 1 <= N_DIGITS <= AN_W, BRIGHT_W <= DIV_W,
// GUARD < 2**(DIV_W-BRIGHT_W).
// -----------------------------------------------------------------------------
module dispn_scan #(
    parameter int N_DIGITS = 4,
    parameter int AN_W     = 8,
    parameter int DIV_W    = 13,
    parameter int BRIGHT_W = 4,
    parameter int GUARD    = 16
) (
    input  logic         clk,
    input  logic         rst,
    dispn_scan_if.slave  bus
);

    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_DIGITS - 1);
    localparam logic [DIV_W-1:0] GUARD_C  = DIV_W'(GUARD);

    // Active-low segment patterns, seg[6:0] = gfedcba.
    function automatic logic [6:0] decode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // Scan state
    logic [DIV_W-1:0]      divcnt_q, divcnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;

    // Shadow and active display contents
    logic [4*N_DIGITS-1:0] shadow_data_q, shadow_data_d;
    logic [N_DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
    logic [N_DIGITS-1:0]   shadow_en_q, shadow_en_d;
    logic [4*N_DIGITS-1:0] active_data_q, active_data_d;
    logic [N_DIGITS-1:0]   active_dp_q, active_dp_d;
    logic [N_DIGITS-1:0]   active_en_q, active_en_d;
    logic                  pending_q, pending_d;
    logic                  frame_done_q, frame_done_d;

    // Registered pin outputs
    logic [AN_W-1:0]       an_q, an_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;

    logic                  commit;
    logic                  lit;
    logic [3:0]            cur_nibble;
    logic [N_DIGITS-1:0]   blank;

    // Leading-zero blanking: walk from the most significant digit down,
    // remembering whether any enabled digit above held a nonzero nibble.
    // Disabled digits never set that flag, so they cannot stop blanking.
    always_comb begin : lzb_blk
        logic nz_above;
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        blank    = '0;
        nz_above = 1'b0;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            if (bus.lzb && (i > 0) && (active_data_q[4*i +: 4] == 4'h0) && !nz_above)
                blank[i] = 1'b1;
            if (active_en_q[i] && (active_data_q[4*i +: 4] != 4'h0))
                nz_above = 1'b1;
        end
    end

    always_comb begin
        // Scan counters
        divcnt_d = divcnt_q + DIV_W'(1);
        idx_d    = idx_q;
        if (&divcnt_q)
            idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);

        // Commit only on the very last cycle of the last digit's dwell.
        commit = (&divcnt_q) && (idx_q == LAST_IDX) && pending_q;

        active_data_d = commit ? shadow_data_q : active_data_q;
        active_dp_d   = commit ? shadow_dp_q   : active_dp_q;
        active_en_d   = commit ? shadow_en_q   : active_en_q;

        shadow_data_d = bus.load ? bus.data  : shadow_data_q;
        shadow_dp_d   = bus.load ? bus.dp_in : shadow_dp_q;
        shadow_en_d   = bus.load ? bus.en_in : shadow_en_q;

        // A load on the commit cycle keeps pending set for the next frame.
        pending_d    = bus.load | (pending_q & ~commit);
        frame_done_d = commit;

        // Pin outputs for the current (divcnt, idx), registered below.
        cur_nibble = active_data_q[4*idx_q +: 4];
        lit = (divcnt_q >= GUARD_C)
           && (divcnt_q[DIV_W-1 -: BRIGHT_W] <= bus.bright)
           && active_en_q[idx_q]
           && !blank[idx_q];

        an_d  = lit ? ~(AN_W'(1) << idx_q) : '1;
        seg_d = lit ? decode(cur_nibble)   : 7'h7F;
        dp_d  = lit ? ~active_dp_q[idx_q]  : 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            divcnt_q      <= '0;
            idx_q         <= '0;
            // NOTE: the content registers are reset too: an all-zero enable
            // mask is what keeps the display dark until the first commit.
            shadow_data_q <= '0;
            shadow_dp_q   <= '0;
            shadow_en_q   <= '0;
            active_data_q <= '0;
            active_dp_q   <= '0;
            active_en_q   <= '0;
            pending_q     <= 1'b0;
            frame_done_q  <= 1'b0;
            an_q          <= '1;
            seg_q         <= 7'h7F;
            dp_q          <= 1'b1;
        end else begin
            divcnt_q      <= divcnt_d;
            idx_q         <= idx_d;
            shadow_data_q <= shadow_data_d;
            shadow_dp_q   <= shadow_dp_d;
            shadow_en_q   <= shadow_en_d;
            active_data_q <= active_data_d;
            active_dp_q   <= active_dp_d;
            active_en_q   <= active_en_d;
            pending_q     <= pending_d;
            frame_done_q  <= frame_done_d;
            an_q          <= an_d;
            seg_q         <= seg_d;
            dp_q          <= dp_d;
        end
    end

    assign bus.an         = an_q;
    assign bus.seg        = seg_q;
    assign bus.dp         = dp_q;
    assign bus.pending    = pending_q;
    assign bus.frame_done = frame_done_q;

endmodule

// File: doc/dispn_scan.md
Name: dispn_scan

Overview:
- Parametrised N-digit multiplexed 7-segment display driver; successor to the fixed 4-digit hex scanner.
- Adds per-digit enable, per-digit decimal point, leading-zero blanking, PWM brightness and an anti-ghosting guard.
- Display contents are double-buffered and committed only at frame boundaries, so updates never tear.
- Sits between the application datapath and the board anode/segment pins.

Parameters:
- N_DIGITS, 4: number of scanned digits, 1..AN_W.
- AN_W, 8: physical anode count; anodes N_DIGITS..AN_W-1 are held high.
- DIV_W, 13: digit dwell is 2^DIV_W clk cycles (8192 cycles, about 12.2 kHz per digit at 100 MHz).
- BRIGHT_W, 4: brightness control width; must satisfy BRIGHT_W <= DIV_W.
- GUARD, 16: blank cycles at the start of each dwell; must satisfy GUARD < 2^(DIV_W-BRIGHT_W).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- data  in  4*N_DIGITS  hex nibbles; digit i = data[4i+3:4i]
- dp_in  in  N_DIGITS  decimal point request per digit, 1 = lit
- en_in  in  N_DIGITS  digit enable, 1 = shown
- load  in  1  one-cycle strobe; captures data, dp_in and en_in into the shadow registers
- lzb  in  1  leading-zero blanking enable; live input, not buffered
- bright  in  BRIGHT_W  on-time code; 0 = minimum, all-ones = full
- an  out  AN_W  anodes, active low
- seg  out  7  segments, active low; seg[0]=a .. seg[6]=g
- dp  out  1  decimal point, active low
- pending  out  1  shadow holds an uncommitted load
- frame_done  out  1  one-cycle pulse on each commit

Behaviour:
- Reset (asynchronous) values:
  - an = all 1, seg = 7'h7F, dp = 1, pending = 0, frame_done = 0.
  - divcnt = 0, digit index idx = 0.
  - Active and shadow registers = 0, so all digits are disabled and the display is dark until the first commit.
  - Reset mid-frame abandons the frame and any pending load.
- Scan:
  - divcnt is DIV_W bits and free-running. When divcnt wraps from 2^DIV_W-1 to 0, idx increments; idx wraps from N_DIGITS-1 to 0.
- Digit lit condition, evaluated each cycle; all four must hold:
  - divcnt >= GUARD.
  - divcnt[DIV_W-1 -: BRIGHT_W] <= bright.
  - active_en[idx] = 1.
  - The digit is not leading-zero blanked.
- Output timing:
  - When lit, an[idx] = 0 and all other anodes = 1; seg = decode(nibble[idx]); dp = ~active_dp[idx].
  - Otherwise an = all 1, seg = 7'h7F, dp = 1.
  - an, seg and dp are registered, one cycle after the (divcnt, idx) state that selects them.
- Leading-zero blanking, when lzb = 1:
  - Digit i is blanked if i > 0, its nibble is 0, and every enabled digit j > i also has nibble 0.
  - Disabled digits neither count as nonzero nor stop blanking.
  - Digit 0 is never blanked.
- Decoder (active low, seg[6:0] = gfedcba), nibbles 0..F:
  - 40, 79, 24, 30, 19, 12, 02, 78, 00, 10, 08, 03, 46, 21, 06, 0E.
- Load and commit:
  - load = 1 copies data, dp_in and en_in into the shadow registers and sets pending = 1.
  - A further load while pending = 1 overwrites the shadow; the latest load wins.
  - Commit cycle: idx = N_DIGITS-1 and divcnt = 2^DIV_W-1. If pending = 1, active <= shadow, pending <= 0 and frame_done = 1 for exactly that clock edge's result.
  - New contents are visible from the first cycle of digit 0.
  - If load coincides with the commit cycle, the previous shadow commits, the new values are captured, and pending stays 1 for the next frame.
- bright and lzb are sampled live, so they may change mid-frame.

Test Plan:
(Bench parameters: N_DIGITS=4, AN_W=8, DIV_W=4 (dwell 16), BRIGHT_W=2, GUARD=2.)
- Reset check: assert rst mid-scan -> an=8'hFF, seg=7'h7F, dp=1 and pending=0 immediately; display stays dark until the first commit after release.
- Basic scan: load data=16'h1234, en=4'hF, dp_in=4'b0100, bright=3, then wait for frame_done.
  - Each dwell: an[idx] low for cycles 3..16 after dwell start (guard plus 1-cycle latency).
  - Digit 0 shows seg=7'h19 ("4"); digit 2 shows seg=7'h24 ("2") with dp=0.
  - an[7:4] stay high throughout.
- Brightness: bright=0 -> an[idx] low only for divcnt 2..3, i.e. 2 of 16 cycles; bright=1 -> divcnt 2..7.
- Leading-zero blanking: data=16'h0050, en=4'hF, lzb=1 -> digits 3 and 2 dark, digit 1 seg=7'h12, digit 0 seg=7'h40.
  - data=0 -> only digit 0 lit, showing "0".
  - lzb=0 -> all four digits lit.
- Double buffering:
  - Load 16'hAAAA, then 16'hBBBB during frame 1 -> pending=1 until the commit; only "b" (7'h03) is ever displayed; frame_done pulses once.
  - Load on the exact commit cycle -> pending stays 1 and a second frame_done occurs one frame later.
- Enable mask: en=4'b1010 -> an[0] and an[2] never go low; frame timing is unchanged at 64 cycles per frame.
